// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared constants, state type and helpers for the LED-matrix
//            frame-buffer loader.
//            ADR_W / RGB_W     - frame-buffer address and pixel widths
//            MATRIX_PIXELS     - frame-buffer depth
//            ADDR_HI_MASK      - live bits of the first (high) address byte
//            PIX_MSB / PIX_LSB - pixel field inside a pixel byte
//            loader_state_t    - SPI loader transaction state
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

   localparam int ADR_W         = 10;
   localparam int RGB_W         = 3;
   localparam int MATRIX_PIXELS = 1024;

   localparam logic [1:0] ADDR_HI_MASK = 2'b11;
   localparam int         PIX_MSB      = 2;
   localparam int         PIX_LSB      = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADDR_HI = 2'd1,
      ADDR_LO = 2'd2,
      PIXEL   = 2'd3
   } loader_state_t;

   // Address increment that wraps at the end of the frame buffer.
   function automatic logic [ADR_W-1:0] next_addr(input logic [ADR_W-1:0] a);
      return (a == ADR_W'(MATRIX_PIXELS - 1)) ? '0 : a + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pixel_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_pixel_loader_if
// Purpose  : Bundles the SPI pins and the frame-buffer write port of the
//            pixel loader.
//            sclk, cs_n, mosi  - SPI host -> loader
//            miso              - loader -> SPI host
//            we, adr_in, rgb_in- frame-buffer write port
//            frame_done, busy  - transaction status
//            Modports: slave  (the loader), master (host / frame-buffer side)
// Revision : 1.0 - initial release
// ============================================================================
interface spi_pixel_loader_if;
   import matrix_pkg::*;

   logic             sclk;
   logic             cs_n;
   logic             mosi;
   logic             miso;
   logic             we;
   logic [ADR_W-1:0] adr_in;
   logic [RGB_W-1:0] rgb_in;
   logic             frame_done;
   logic             busy;

   modport slave (
      input  sclk, cs_n, mosi,
      output miso, we, adr_in, rgb_in, frame_done, busy
   );

   modport master (
      output sclk, cs_n, mosi,
      input  miso, we, adr_in, rgb_in, frame_done, busy
   );

endinterface
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Two-flop synchroniser for an asynchronous input, followed by an
//            edge-detect flop and registered one-cycle rise/fall pulses.
//            A pin edge shows up on o_rise/o_fall three clk cycles later.
// Ports    : clk, rst_n (async, active low)
//            i_async  - asynchronous input pin
//            o_sync   - synchronised level (2 cycles of latency)
//            o_rise   - one-cycle pulse on a rising edge
//            o_fall   - one-cycle pulse on a falling edge
// Params   : RST_VAL - reset value of every internal stage
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic r_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_pixel_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_pixel_loader
// Purpose  : SPI-slave (mode 0, MSB first) front end that fills the LED-matrix
//            frame buffer. A transaction carries a 10-bit start address in two
//            bytes followed by pixel bytes; each pixel byte produces one
//            frame-buffer write and advances the address (wrapping at 1024).
// Ports    : clk            - system clock (shared with fpga_matrix)
//            rst_n          - asynchronous active-low reset
//            bus (slave)    - sclk/cs_n/mosi/miso SPI pins, we/adr_in/rgb_in
//                             write port, frame_done and busy status
// Config   : SPI_LOADER_READBACK_EN - when defined, miso shifts out the last
//            completed byte (MSB first, updated on sclk falling edges);
//            otherwise miso is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pixel_loader (
   input  logic               clk,
   input  logic               rst_n,
   spi_pixel_loader_if.slave  bus
);
   import matrix_pkg::*;

   // ------------------------------------------------------------------
   // Pin synchronisation
   // ------------------------------------------------------------------
   logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
   logic w_cs_sync,   w_cs_rise,   w_cs_fall;

   sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (bus.sclk),
      .o_sync  (w_sclk_sync),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   // cs_n resets to "low" on purpose: if the pin is already low when reset
   // releases, no falling edge is seen and the loader stays idle until the
   // host deasserts and reasserts chip select.
   sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (bus.cs_n),
      .o_sync  (w_cs_sync),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   logic r_mosi_meta;
   logic r_mosi_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_mosi_meta <= bus.mosi;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   // Set once cs_n has been seen high after reset; busy is qualified with it
   // so that a chip select held low across reset is not reported as busy.
   logic r_armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_armed <= 1'b0;
      else if (w_cs_sync) r_armed <= 1'b1;
   end

   // ------------------------------------------------------------------
   // Byte assembly
   // ------------------------------------------------------------------
   loader_state_t r_state;
   loader_state_t w_next_state;

   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift;     // first seven bits; the eighth comes straight from mosi
   logic [7:0] w_byte;
   logic       w_byte_done;
   logic       w_start;

   assign w_byte      = {r_shift, r_mosi_sync};
   assign w_byte_done = w_sclk_rise && (r_state != IDLE) && (r_bit_cnt == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= 3'd0;
         r_shift   <= 7'd0;
      end else if (w_start || w_cs_rise) begin
         // A partial byte at chip-select release is simply dropped here.
         r_bit_cnt <= 3'd0;
      end else if (w_sclk_rise && (r_state != IDLE)) begin
         r_bit_cnt <= r_bit_cnt + 3'd1;
         r_shift   <= {r_shift[5:0], r_mosi_sync};
      end
   end

   // ------------------------------------------------------------------
   // Transaction state machine
   // ------------------------------------------------------------------
   logic w_load_hi;
   logic w_load_lo;
   logic w_pix_wr;
   logic w_fd_set;
   logic r_wrote;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_load_hi    = 1'b0;
      w_load_lo    = 1'b0;
      w_pix_wr     = 1'b0;
      w_fd_set     = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_cs_fall) begin
               w_start      = 1'b1;
               w_next_state = ADDR_HI;
            end
         end
         ADDR_HI: begin
            if (w_byte_done) begin
               w_load_hi    = 1'b1;
               w_next_state = ADDR_LO;
            end
         end
         ADDR_LO: begin
            if (w_byte_done) begin
               w_load_lo    = 1'b1;
               w_next_state = PIXEL;
            end
         end
         PIXEL: begin
            if (w_byte_done) w_pix_wr = 1'b1;
         end
         default: w_next_state = IDLE;
      endcase

      // Chip-select release wins the state, but a byte completing in the
      // same cycle is still honoured above and counts toward frame_done.
      if (w_cs_rise && (r_state != IDLE)) begin
         w_next_state = IDLE;
         if ((r_state == PIXEL) && (r_wrote || w_pix_wr)) w_fd_set = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Address register and frame-buffer write port
   // ------------------------------------------------------------------
   logic [ADR_W-1:0] r_addr;
   logic             r_we;
   logic [ADR_W-1:0] r_adr_out;
   logic [RGB_W-1:0] r_rgb_out;
   logic             r_frame_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= '0;
         r_wrote      <= 1'b0;
         r_we         <= 1'b0;
         r_adr_out    <= '0;
         r_rgb_out    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_we         <= w_pix_wr;
         r_frame_done <= w_fd_set;

         if (w_start)       r_wrote <= 1'b0;
         else if (w_pix_wr) r_wrote <= 1'b1;

         if (w_load_hi) r_addr[ADR_W-1 -: 2] <= w_byte[1:0] & ADDR_HI_MASK;
         if (w_load_lo) r_addr[7:0]          <= w_byte;

         if (w_pix_wr) begin
            // adr_in/rgb_in only change with a write so they are stable
            // around the we strobe that fpga_matrix edge-detects.
            r_adr_out <= r_addr;
            r_rgb_out <= w_byte[PIX_MSB:PIX_LSB];
            r_addr    <= next_addr(r_addr);
         end
      end
   end

   assign bus.we         = r_we;
   assign bus.adr_in     = r_adr_out;
   assign bus.rgb_in     = r_rgb_out;
   assign bus.frame_done = r_frame_done;
   assign bus.busy       = ~w_cs_sync & r_armed;

   // ------------------------------------------------------------------
   // Optional readback of the last completed byte on miso
   // ------------------------------------------------------------------
   logic w_sclk_unused;

`ifdef SPI_LOADER_READBACK_EN
   logic [7:0] r_rb;
   logic       r_miso;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rb   <= 8'd0;
         r_miso <= 1'b0;
      end else begin
         // Rotating (rather than shifting) keeps the byte intact, so the
         // same value is presented again if the host clocks past 8 bits.
         if (w_byte_done)      r_rb <= w_byte;
         else if (w_sclk_fall) r_rb <= {r_rb[6:0], r_rb[7]};

         if (w_cs_sync)        r_miso <= 1'b0;
         else if (w_sclk_fall) r_miso <= r_rb[7];
      end
   end

   assign bus.miso      = r_miso;
   assign w_sclk_unused = w_sclk_sync;
`else
   assign bus.miso      = 1'b0;
   assign w_sclk_unused = w_sclk_sync ^ w_sclk_fall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_pixel_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_pixel_loader
// Purpose  : Self-checking bench for spi_pixel_loader. Drives SPI mode-0
//            transactions, records frame-buffer writes and frame_done pulses,
//            and compares them with a transaction-level model and a table of
//            known vectors. Honours SPI_LOADER_READBACK_EN for miso checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_pixel_loader;
   import matrix_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_pixel_loader_if bus();

   spi_pixel_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [RGB_W-1:0] rgb;
   } wr_t;

   typedef struct packed {
      logic [47:0]      bytes;   // first byte in [47:40]
      logic [2:0]       nb;
      logic [2:0]       tail;    // trailing partial-byte bits
      logic [1:0]       nw;
      logic [ADR_W-1:0] a0;
      logic [RGB_W-1:0] r0;
      logic [ADR_W-1:0] a1;
      logic [RGB_W-1:0] r1;
      logic             fd;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   wr_t  obs_q[$];
   wr_t  exp_q[$];
   bit   exp_fd;
   int   fd_cnt = 0;
   int   we_run = 0;
   int   max_we_run = 0;
   int   miso_hi = 0;
   wr_t  mon_w;
   logic [7:0] tx_q[$];

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         if (we_run == 0) begin
            mon_w.adr = bus.adr_in;
            mon_w.rgb = bus.rgb_in;
            obs_q.push_back(mon_w);
         end
         we_run++;
         if (we_run > max_we_run) max_we_run = we_run;
      end else begin
         we_run = 0;
      end
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.miso !== 1'b0) miso_hi++;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clkn(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b);
      bus.mosi = b;
      clkn(5);
      bus.sclk = 1'b1;
      clkn(5);
      bus.sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) spi_bit(v[i]);
   endtask

   task automatic send_txn(input int tail);
      bus.cs_n = 1'b0;
      clkn(6);
      chk("busy_active", bus.busy, 1);
      foreach (tx_q[k]) spi_byte(tx_q[k]);
      for (int i = 0; i < tail; i++) spi_bit(1'($urandom_range(0, 1)));
      clkn(5);
      bus.cs_n = 1'b1;
      clkn(10);
   endtask

   // Reference: address = low two bits of byte 0 then byte 1; every further
   // whole byte writes its low three bits at successive addresses mod 1024.
   task automatic model();
      int  base;
      wr_t w;
      exp_q.delete();
      exp_fd = 1'b0;
      if (tx_q.size() >= 3) begin
         base = (int'(tx_q[0]) % 4) * 256 + int'(tx_q[1]);
         for (int k = 2; k < tx_q.size(); k++) begin
            w.adr = ADR_W'((base + k - 2) % MATRIX_PIXELS);
            w.rgb = RGB_W'(int'(tx_q[k]) % 8);
            exp_q.push_back(w);
         end
         exp_fd = 1'b1;
      end
   endtask

   task automatic compare(input string tag, input bit hold);
      chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk({tag, "_adr"}, obs_q[i].adr, exp_q[i].adr);
         chk({tag, "_rgb"}, obs_q[i].rgb, exp_q[i].rgb);
      end
      chk({tag, "_frame_done"}, fd_cnt, int'(exp_fd));
      if (exp_q.size() > 0) chk({tag, "_we_width"}, max_we_run, 1);
      if (hold && exp_q.size() > 0) begin
         chk({tag, "_adr_hold"}, bus.adr_in, exp_q[exp_q.size()-1].adr);
         chk({tag, "_rgb_hold"}, bus.rgb_in, exp_q[exp_q.size()-1].rgb);
      end
      chk({tag, "_busy_idle"}, bus.busy, 0);
      obs_q.delete();
      fd_cnt     = 0;
      max_we_run = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_we"}, bus.we, 0);
      chk({tag, "_adr_in"}, bus.adr_in, 0);
      chk({tag, "_rgb_in"}, bus.rgb_in, 0);
      chk({tag, "_miso"}, bus.miso, 0);
      chk({tag, "_frame_done"}, bus.frame_done, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5ms;
      fails++;
      $display("FAIL watchdog: got timeout, expected end of test");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      vec_t       tbl[7];
      vec_t       v;
      wr_t        w;
      logic [7:0] rb;
      logic [7:0] exp_rb;

      tbl[0] = '{48'h00_05_07_02_00_00, 3'd4, 3'd0, 2'd2, 10'd5,    3'd7, 10'd6, 3'd2, 1'b1};
      tbl[1] = '{48'h03_FF_01_04_00_00, 3'd4, 3'd0, 2'd2, 10'd1023, 3'd1, 10'd0, 3'd4, 1'b1};
      tbl[2] = '{48'h00_10_00_00_00_00, 3'd2, 3'd5, 2'd0, 10'd0,    3'd0, 10'd0, 3'd0, 1'b0};
      tbl[3] = '{48'hFE_00_FD_00_00_00, 3'd3, 3'd0, 2'd1, 10'h200,  3'd5, 10'd0, 3'd0, 1'b1};
      tbl[4] = '{48'h01_20_00_00_00_00, 3'd2, 3'd0, 2'd0, 10'd0,    3'd0, 10'd0, 3'd0, 1'b0};
      tbl[5] = '{48'h02_34_06_00_00_00, 3'd3, 3'd0, 2'd1, 10'h234,  3'd6, 10'd0, 3'd0, 1'b1};
      tbl[6] = '{48'h00_00_03_00_00_00, 3'd3, 3'd3, 2'd1, 10'd0,    3'd3, 10'd0, 3'd0, 1'b1};

      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      clkn(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      clkn(10);

      // Table vectors
      for (int t = 0; t < 7; t++) begin
         v = tbl[t];
         tx_q.delete();
         for (int k = 0; k < int'(v.nb); k++) tx_q.push_back(v.bytes[47-8*k -: 8]);
         send_txn(int'(v.tail));
         exp_q.delete();
         if (v.nw >= 2'd1) begin w.adr = v.a0; w.rgb = v.r0; exp_q.push_back(w); end
         if (v.nw >= 2'd2) begin w.adr = v.a1; w.rgb = v.r1; exp_q.push_back(w); end
         exp_fd = v.fd;
         compare($sformatf("vec%0d", t), 1'b1);
      end

      // Reset in the middle of a transaction
      tx_q = '{8'h01, 8'h20, 8'h06};
      bus.cs_n = 1'b0;
      clkn(6);
      foreach (tx_q[k]) spi_byte(tx_q[k]);
      clkn(5);
      rst_n = 1'b0;
      clkn(2);
      check_all_zero("rst_mid");
      model();
      exp_fd = 1'b0;
      compare("rst_pre", 1'b0);
      rst_n = 1'b1;
      clkn(10);
      spi_byte(8'h01);
      spi_byte(8'h20);
      spi_byte(8'h06);
      chk("rst_post_busy", bus.busy, 0);
      clkn(5);
      bus.cs_n = 1'b1;
      clkn(10);
      exp_q.delete();
      exp_fd = 1'b0;
      compare("rst_post", 1'b0);
      tx_q = '{8'h00, 8'h07, 8'h05};
      send_txn(0);
      model();
      compare("rst_fresh", 1'b1);

      // Last bit's sclk rise and cs_n release on the same cycle
      bus.cs_n = 1'b0;
      clkn(6);
      spi_byte(8'h00);
      spi_byte(8'h09);
      for (int i = 7; i >= 1; i--) spi_bit(i <= 1);
      bus.mosi = 1'b1;
      clkn(5);
      bus.sclk = 1'b1;
      bus.cs_n = 1'b1;
      clkn(5);
      bus.sclk = 1'b0;
      clkn(10);
      exp_q.delete();
      w.adr = 10'd9;
      w.rgb = 3'd3;
      exp_q.push_back(w);
      exp_fd = 1'b1;
      compare("simul", 1'b1);

      // miso readback of 0xA5 during the following byte
`ifdef SPI_LOADER_READBACK_EN
      exp_rb = 8'hA5;
`else
      exp_rb = 8'h00;
`endif
      tx_q = '{8'h00, 8'h00, 8'hA5};
      bus.cs_n = 1'b0;
      clkn(6);
      foreach (tx_q[k]) spi_byte(tx_q[k]);
      rb = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         bus.mosi = 1'b0;
         clkn(5);
         rb[i] = bus.miso;
         bus.sclk = 1'b1;
         clkn(5);
         bus.sclk = 1'b0;
      end
      clkn(5);
      bus.cs_n = 1'b1;
      clkn(10);
      chk("miso_readback", rb, exp_rb);
      chk("miso_cs_high", bus.miso, 0);
      tx_q.push_back(8'h00);
      model();
      compare("readback", 1'b1);

      // Randomised transactions against the model
      for (int r = 0; r < 20; r++) begin
         int nb;
         int tail;
         nb   = $urandom_range(1, 6);
         tail = $urandom_range(0, 7);
         tx_q.delete();
         for (int k = 0; k < nb; k++) tx_q.push_back(8'($urandom));
         send_txn(tail);
         model();
         compare($sformatf("rand%0d", r), 1'b1);
      end

`ifndef SPI_LOADER_READBACK_EN
      chk("miso_stuck_zero", miso_hi, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
